apb_cmd_slave: RTL and testbench
================================

APB_CMD_SLAVE -- requirements
Module: apb_cmd_slave

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 32, giving the APB data, command and status word width.
REQ-002 The block SHALL have the parameter ADDR_W, default 8, giving the PADDR width; it SHALL be at least 2 + clog2(3 + NUM_STATUS).
REQ-003 The block SHALL have the parameter NUM_STATUS, default 4, giving the number of read-only status words.
REQ-004 The block SHALL have the parameter TIMEOUT, default 16, giving the maximum number of cycles spent in CMD_WAIT; 0 disables the timeout.
REQ-005 The block SHALL have these ports:
  pclk  in  1  clock; all state updates on its rising edge
  n_rst  in  1  asynchronous active-low reset
  PSEL  in  1  APB select
  PENABLE  in  1  APB access phase
  PWRITE  in  1  1 = write, 0 = read
  PADDR  in  ADDR_W  byte address; bits [1:0] ignored
  PWDATA  in  DATA_W  write data
  PRDATA  out  DATA_W  read data
  PREADY  out  1  transfer complete
  PSLVERR  out  1  transfer error
  status_in  in  NUM_STATUS*DATA_W  status words; word i = bits [i*DATA_W +: DATA_W]
  cmd_data  out  DATA_W  command word to the decoder
  cmd_valid  out  1  command offered
  cmd_ready  in  1  decoder accepts the command

Function
REQ-006 The register index SHALL be idx = PADDR[ADDR_W-1:2], mapped as follows:
  0 CMD: write issues a command; read returns the last accepted command.
  1 CTRL: R/W; bit0 = enable; other bits read 0.
  2 CMD_COUNT: read-only count of accepted commands, DATA_W wide, wraps modulo 2^DATA_W.
  3 .. 2+NUM_STATUS STATUS[idx-3]: read-only.
REQ-007 Any idx outside the map SHALL complete with PSLVERR=1 and PRDATA=0; a write to such an idx SHALL change no state.
REQ-008 The FSM SHALL have three states: IDLE, ACCESS and CMD_WAIT.
REQ-009 In IDLE, PSEL=1 with PENABLE=0 (setup) SHALL latch PADDR, PWRITE and PWDATA, and register the read data for idx.
  - The next state SHALL be CMD_WAIT for a write to CMD when CTRL.enable=1.
  - The next state SHALL be ACCESS in all other cases.
REQ-010 In ACCESS, the block SHALL drive PREADY=1 and the registered PRDATA (0 for writes).
  - PSLVERR SHALL be 1 for an unmapped idx, a write to a read-only idx (2 .. 2+NUM_STATUS), or a write to CMD while CTRL.enable=0.
  - Writes to CTRL SHALL commit on this edge.
  - The next state SHALL be IDLE.
REQ-011 In CMD_WAIT, the block SHALL drive cmd_valid=1, cmd_data = latched PWDATA, PREADY=cmd_ready and PSLVERR=0.
  - When cmd_ready=1: the next state SHALL be IDLE, CMD_COUNT SHALL increment and the last command SHALL update.
REQ-012 cmd_data SHALL hold stable while cmd_valid=1; cmd_valid SHALL deassert only after a handshake, a timeout or an abort.
REQ-013 Timeout: when TIMEOUT>0 and TIMEOUT cycles pass in CMD_WAIT without cmd_ready, the next cycle SHALL drive PREADY=1, PSLVERR=1 and cmd_valid=0, then return to IDLE; CMD_COUNT SHALL be unchanged.
  - A cmd_ready arriving on that same cycle SHALL win over the timeout.
REQ-014 PSEL=0 in ACCESS or CMD_WAIT (protocol violation) SHALL return the FSM to IDLE next cycle, drop cmd_valid, and leave CTRL and CMD_COUNT unchanged.
REQ-015 Outside ACCESS and CMD_WAIT, the block SHALL drive PREADY=1, PSLVERR=0 and cmd_valid=0.
REQ-016 A zero-wait transfer SHALL take exactly 2 cycles (setup + access).
  - A command write SHALL take 2 + N cycles, where N = cycles until cmd_ready.
  - Back-to-back transfers SHALL be supported with no idle cycle.

Reset
REQ-017 n_rst=0 SHALL asynchronously force:
  - state=IDLE, PRDATA=0, PREADY=1, PSLVERR=0
  - cmd_valid=0, cmd_data=0
  - CTRL=0x1, CMD_COUNT=0, last command=0
REQ-018 Reset during CMD_WAIT SHALL drop cmd_valid immediately, and the pending command SHALL NOT be counted.

Verification
REQ-019 Read STATUS[1] with status_in word1=0xCAFE0001 -> PRDATA=0xCAFE0001, PREADY=1, PSLVERR=0 in the access cycle, 2 cycles total.
REQ-020 Write CMD=0x12345678 with cmd_ready held 0 for 3 cycles, then 1 -> cmd_valid high for 4 cycles with cmd_data stable; PREADY=1 on the 4th; CMD_COUNT reads 1; CMD reads 0x12345678.
REQ-021 Write CTRL=0, then write CMD=0xA5 -> cmd_valid never asserts, PSLVERR=1, CMD_COUNT unchanged.
REQ-022 TIMEOUT=16, write CMD with cmd_ready=0 -> after 16 wait cycles PREADY=1, PSLVERR=1, cmd_valid=0; CMD_COUNT unchanged.
REQ-023 Write to CMD_COUNT and read idx 3+NUM_STATUS -> PSLVERR=1 for both, PRDATA=0 for the read, no state change.
REQ-024 Assert n_rst=0 mid-CMD_WAIT -> cmd_valid=0 within the same cycle; after release, CTRL reads 0x1 and CMD_COUNT reads 0.

Source files
------------

// File: rtl/apb_cmd_slave.sv
// APB register slave that forwards CMD writes to a valid/ready command port,
// with a register map of control, command count and read-only status words.
module apb_cmd_slave #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int NUM_STATUS = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                         pclk,
    input  logic                         n_rst,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_W-1:0]            PADDR,
    input  logic [DATA_W-1:0]            PWDATA,
    output logic [DATA_W-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    input  logic [NUM_STATUS*DATA_W-1:0] status_in,
    output logic [DATA_W-1:0]            cmd_data,
    output logic                         cmd_valid,
    input  logic                         cmd_ready
);

    localparam int IW = ADDR_W - 2;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IW-1:0] IDX_CMD  = IW'(0);
    localparam logic [IW-1:0] IDX_CTRL = IW'(1);
    localparam logic [IW-1:0] IDX_CNT  = IW'(2);

    typedef enum logic [1:0] {IDLE, ACCESS, CMD_WAIT} state_t;

    state_t            state_reg, state_next;
    logic [IW-1:0]     idx_reg;
    logic              write_reg;
    logic              err_reg;
    logic              ctrl_en_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [DATA_W-1:0] last_cmd_reg;
    logic [DATA_W-1:0] cmd_count_reg;
    logic [CW-1:0]     wait_cnt_reg;

    logic [IW-1:0]     idx_in;
    logic [DATA_W-1:0] rd_mux;
    logic              idx_mapped, idx_ro, setup_err;
    logic              setup_fire, ctrl_we, cmd_accept, timeout_hit;
    logic [DATA_W-1:0] status_w [NUM_STATUS];
    logic              unused_paddr_lsb;

    assign idx_in           = PADDR[ADDR_W-1:2];
    assign unused_paddr_lsb = ^PADDR[1:0];

    generate
        for (genvar gi = 0; gi < NUM_STATUS; gi++) begin : g_status
            assign status_w[gi] = status_in[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Register-map decode for the address presented during setup
    always_comb begin
        rd_mux     = '0;
        idx_mapped = 1'b0;
        idx_ro     = 1'b0;
        if (idx_in == IDX_CMD) begin
            rd_mux     = last_cmd_reg;
            idx_mapped = 1'b1;
        end else if (idx_in == IDX_CTRL) begin
            rd_mux     = {{(DATA_W-1){1'b0}}, ctrl_en_reg};
            idx_mapped = 1'b1;
        end else if (idx_in == IDX_CNT) begin
            rd_mux     = cmd_count_reg;
            idx_mapped = 1'b1;
            idx_ro     = 1'b1;
        end
        for (int i = 0; i < NUM_STATUS; i++) begin
            if (idx_in == IW'(i + 3)) begin
                rd_mux     = status_w[i];
                idx_mapped = 1'b1;
                idx_ro     = 1'b1;
            end
        end
        setup_err = !idx_mapped || (PWRITE && idx_ro) ||
                    (PWRITE && (idx_in == IDX_CMD) && !ctrl_en_reg);
    end

    always_comb begin
        state_next  = state_reg;
        setup_fire  = 1'b0;
        ctrl_we     = 1'b0;
        cmd_accept  = 1'b0;
        timeout_hit = 1'b0;
        PREADY      = 1'b1;
        PSLVERR     = 1'b0;
        cmd_valid   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    setup_fire = 1'b1;
                    state_next = (PWRITE && (idx_in == IDX_CMD) && ctrl_en_reg) ? CMD_WAIT : ACCESS;
                end
            end
            ACCESS: begin
                PSLVERR    = err_reg;
                ctrl_we    = PSEL && write_reg && (idx_reg == IDX_CTRL) && !err_reg;
                state_next = IDLE;
            end
            CMD_WAIT: begin
                if (!PSEL) begin
                    state_next = IDLE;
                end else begin
                    cmd_valid = 1'b1;
                    PREADY    = cmd_ready;
                    if (cmd_ready) begin
                        cmd_accept = 1'b1;
                        state_next = IDLE;
                    end else if ((TIMEOUT > 0) && (wait_cnt_reg == TO_LAST)) begin
                        // Timed-out command finishes through ACCESS with an error
                        timeout_hit = 1'b1;
                        state_next  = ACCESS;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge pclk or negedge n_rst) begin
        if (!n_rst) begin
            idx_reg       <= '0;
            write_reg     <= 1'b0;
            err_reg       <= 1'b0;
            ctrl_en_reg   <= 1'b1;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            last_cmd_reg  <= '0;
            cmd_count_reg <= '0;
            wait_cnt_reg  <= '0;
        end else begin
            if (setup_fire) begin
                idx_reg      <= idx_in;
                write_reg    <= PWRITE;
                wdata_reg    <= PWDATA;
                rdata_reg    <= PWRITE ? '0 : rd_mux;
                err_reg      <= setup_err;
                wait_cnt_reg <= '0;
            end
            if (ctrl_we) begin
                ctrl_en_reg <= wdata_reg[0];
            end
            if (cmd_accept) begin
                cmd_count_reg <= cmd_count_reg + DATA_W'(1);
                last_cmd_reg  <= wdata_reg;
            end
            if (timeout_hit) begin
                err_reg <= 1'b1;
            end else if (state_reg == CMD_WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + CW'(1);
            end
        end
    end

    assign PRDATA   = (state_reg == ACCESS) ? rdata_reg : '0;
    assign cmd_data = wdata_reg;

endmodule

// File: tb/tb_apb_cmd_slave.sv
// Directed plus randomized APB transfers against a register-map reference model.
module tb_apb_cmd_slave;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 8;
    localparam int NUM_STATUS = 4;
    localparam int TIMEOUT    = 16;

    logic                         pclk = 1'b0;
    logic                         n_rst = 1'b1;
    logic                         PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [ADDR_W-1:0]            PADDR = '0;
    logic [DATA_W-1:0]            PWDATA = '0;
    logic [DATA_W-1:0]            PRDATA;
    logic                         PREADY, PSLVERR;
    logic [NUM_STATUS*DATA_W-1:0] status_in = '0;
    logic [DATA_W-1:0]            cmd_data;
    logic                         cmd_valid;
    logic                         cmd_ready = 1'b0;

    apb_cmd_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_STATUS(NUM_STATUS), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .n_rst(n_rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .status_in(status_in), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic              m_ctrl;
    logic [DATA_W-1:0] m_count, m_last;
    logic [DATA_W-1:0] m_status [NUM_STATUS];

    // Results of the most recent transfer
    logic [DATA_W-1:0] r_rdata;
    logic              r_err, r_done, r_unstable;
    int                r_cycles, r_valid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_status();
        for (int i = 0; i < NUM_STATUS; i++) begin
            m_status[i] = $urandom;
            status_in[i*DATA_W +: DATA_W] = m_status[i];
        end
    endtask

    task automatic xfer(input bit wr, input int idx, input logic [DATA_W-1:0] wd, input int delay);
        logic [ADDR_W-3:0] idx_bits;
        idx_bits = idx[ADDR_W-3:0];
        @(posedge pclk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = {idx_bits, 2'($urandom_range(0, 3))};
        PWDATA = wd; cmd_ready = 1'b0;
        r_cycles = 1; r_valid = 0; r_unstable = 1'b0; r_done = 1'b0;
        r_rdata = 'x; r_err = 1'bx;
        @(posedge pclk); #1;
        PENABLE = 1'b1;
        for (int n = 0; n < 40 && !r_done; n++) begin
            if (n > 0) begin
                @(posedge pclk); #1;
            end
            cmd_ready = (n >= delay);
            @(negedge pclk);
            r_cycles++;
            if (cmd_valid) begin
                r_valid++;
                if (cmd_data !== wd) r_unstable = 1'b1;
            end
            if (PREADY) begin
                r_done  = 1'b1;
                r_rdata = PRDATA;
                r_err   = PSLVERR;
            end
        end
        check("xfer_completes", 64'(r_done), 64'd1);
    endtask

    task automatic idle();
        @(posedge pclk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; cmd_ready = 1'b0;
    endtask

    // One transfer: predict from the register map, run it, compare everything
    task automatic do_txn(input string tag, input bit wr, input int idx,
                          input logic [DATA_W-1:0] wd, input int delay);
        logic [DATA_W-1:0] e_rdata;
        logic              e_err;
        int                e_cycles, e_valid;
        e_rdata = '0; e_err = 1'b0; e_cycles = 2; e_valid = 0;
        if (!wr) begin
            if (idx == 0)                    e_rdata = m_last;
            else if (idx == 1)               e_rdata = {{(DATA_W-1){1'b0}}, m_ctrl};
            else if (idx == 2)               e_rdata = m_count;
            else if (idx < 3 + NUM_STATUS)   e_rdata = m_status[idx-3];
            else                             e_err   = 1'b1;
        end else if (idx == 0) begin
            if (!m_ctrl) begin
                e_err = 1'b1;
            end else if (delay < TIMEOUT) begin
                e_cycles = delay + 2;
                e_valid  = delay + 1;
                m_count  = m_count + 1;
                m_last   = wd;
            end else begin
                e_err    = 1'b1;
                e_cycles = TIMEOUT + 2;
                e_valid  = TIMEOUT;
            end
        end else if (idx == 1) begin
            m_ctrl = wd[0];
        end else begin
            e_err = 1'b1;
        end
        xfer(wr, idx, wd, delay);
        $display("txn %s wr=%0d idx=%0d wd=0x%08h delay=%0d -> rdata=0x%08h err=%0d cycles=%0d valid=%0d",
                 tag, wr, idx, wd, delay, r_rdata, r_err, r_cycles, r_valid);
        check({tag, "_rdata"},  64'(r_rdata),    64'(e_rdata));
        check({tag, "_err"},    64'(r_err),      64'(e_err));
        check({tag, "_cycles"}, 64'(r_cycles),   64'(e_cycles));
        check({tag, "_valid"},  64'(r_valid),    64'(e_valid));
        check({tag, "_stable"}, 64'(r_unstable), 64'd0);
    endtask

    initial begin
        int r, idx, delay;
        bit wr;
        m_ctrl = 1'b1; m_count = '0; m_last = '0;
        set_status();

        // Reset state
        #2 n_rst = 1'b0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        check("rst_pready",    64'(PREADY),    64'd1);
        check("rst_pslverr",   64'(PSLVERR),   64'd0);
        check("rst_prdata",    64'(PRDATA),    64'd0);
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_cmd_data",  64'(cmd_data),  64'd0);
        n_rst = 1'b1;

        // Status read with a known word
        m_status[1] = 32'hCAFE0001;
        status_in[1*DATA_W +: DATA_W] = 32'hCAFE0001;
        do_txn("status1_read", 1'b0, 4, $urandom, 0);
        check("status1_value", 64'(r_rdata), 64'hCAFE0001);

        // Command with ready after three wait cycles, then read back
        do_txn("cmd_delay3", 1'b1, 0, 32'h12345678, 3);
        do_txn("count_after_cmd", 1'b0, 2, '0, 0);
        check("count_is_one", 64'(r_rdata), 64'd1);
        do_txn("last_cmd_read", 1'b0, 0, '0, 0);
        check("last_cmd_value", 64'(r_rdata), 64'h12345678);

        // Disabled command path
        do_txn("ctrl_off", 1'b1, 1, 32'h0, 0);
        do_txn("cmd_disabled", 1'b1, 0, 32'hA5, 0);
        do_txn("count_unchanged", 1'b0, 2, '0, 0);
        do_txn("ctrl_on", 1'b1, 1, 32'hFFFF_FFFF, 0);
        do_txn("ctrl_read", 1'b0, 1, '0, 0);

        // Timeout, and the ready-on-last-cycle race
        do_txn("cmd_timeout", 1'b1, 0, 32'hDEAD_BEEF, 100);
        do_txn("count_after_to", 1'b0, 2, '0, 0);
        do_txn("cmd_ready_last", 1'b1, 0, 32'h0BAD_F00D, TIMEOUT - 1);
        do_txn("cmd_ready_first", 1'b1, 0, 32'h0000_0042, 0);

        // Read-only and unmapped addresses
        do_txn("write_count", 1'b1, 2, 32'h5555_5555, 0);
        do_txn("read_unmapped", 1'b0, 3 + NUM_STATUS, '0, 0);
        do_txn("write_unmapped", 1'b1, 40, 32'h0, 0);
        do_txn("count_after_ro", 1'b0, 2, '0, 0);
        do_txn("ctrl_after_ro", 1'b0, 1, '0, 0);
        idle();

        // Abort by dropping PSEL mid-wait
        @(posedge pclk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = '0; PWDATA = 32'h5555; cmd_ready = 1'b0;
        @(posedge pclk); #1;
        PENABLE = 1'b1;
        @(negedge pclk);
        check("abort_valid_on", 64'(cmd_valid), 64'd1);
        @(posedge pclk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; cmd_ready = 1'b1;
        @(negedge pclk);
        check("abort_valid_drop", 64'(cmd_valid), 64'd0);
        @(posedge pclk); #1;
        cmd_ready = 1'b0;
        @(negedge pclk);
        check("abort_idle_valid", 64'(cmd_valid), 64'd0);
        $display("txn abort_psel cmd_valid=%0d", cmd_valid);
        do_txn("count_after_abort", 1'b0, 2, '0, 0);
        idle();

        // Asynchronous reset during a pending command
        @(posedge pclk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = '0; PWDATA = 32'h7777; cmd_ready = 1'b0;
        @(posedge pclk); #1;
        PENABLE = 1'b1;
        @(negedge pclk);
        check("rstwait_valid_on", 64'(cmd_valid), 64'd1);
        #2 n_rst = 1'b0;
        #1;
        check("rstwait_valid_drop", 64'(cmd_valid), 64'd0);
        $display("txn reset_in_wait cmd_valid=%0d", cmd_valid);
        @(posedge pclk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge pclk);
        n_rst = 1'b1;
        m_ctrl = 1'b1; m_count = '0; m_last = '0;
        do_txn("ctrl_after_rst", 1'b0, 1, '0, 0);
        do_txn("count_after_rst", 1'b0, 2, '0, 0);
        do_txn("last_after_rst", 1'b0, 0, '0, 0);

        // Randomized back-to-back traffic
        for (int t = 0; t < 60; t++) begin
            set_status();
            r = $urandom_range(0, 9);
            idx = (r == 9) ? int'($urandom_range(7, 63)) : r;
            wr = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 7);
            delay = (r == 6) ? TIMEOUT - 1 : (r == 7) ? TIMEOUT + int'($urandom_range(0, 5)) : r;
            do_txn($sformatf("rnd%0d", t), wr, idx, $urandom, delay);
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
